// File: rtl/cycle_controller.sv
// Instruction-cycle sequencer: steps FETCH/DECODE/EXEC/WB, issues one-cycle datapath strobes,
// handles memory-ready timeout, HALT, single-step pausing and a retired-instruction counter.
module cycle_controller #(
    parameter int              OPW     = 4,
    parameter int              CW      = 8,
    parameter logic [OPW-1:0]  HALT_OP = OPW'(4'hF),
    parameter logic [OPW-1:0]  NOP_OP  = OPW'(4'h0),
    parameter int              MAXWAIT = 15
) (
    input  logic           clk,
    input  logic           clear_n,
    input  logic           start,
    input  logic           step_mode,
    input  logic           step_go,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           mem_rd,
    output logic           ir_load,
    output logic           pc_inc,
    output logic           alu_en,
    output logic           reg_we,
    output logic [1:0]     phase,
    output logic           busy,
    output logic           halted,
    output logic           timeout,
    output logic [CW-1:0]  instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_PAUSE,
        S_HALT
    } state_t;

    // Last FETCH wait cycle: mem_ready still low here means timeout
    localparam logic [7:0] WAIT_LAST = 8'(MAXWAIT - 1);

    state_t         state_q, state_d;
    logic [7:0]     wait_q, wait_d;
    logic [OPW-1:0] op_q, op_d;
    logic           timeout_q, timeout_d;
    logic [CW-1:0]  count_q, count_d;
    logic           retire;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            op_q      <= '0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            op_q      <= op_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
        end
    end

    // Wait counter defaults to zero, so it is already clear on every entry to FETCH
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        op_d      = op_q;
        timeout_d = timeout_q;
        count_d   = count_q;
        retire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (opcode == HALT_OP) state_d = S_HALT;
                else                   state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op_q == NOP_OP) retire  = 1'b1;
                else                state_d = S_WB;
            end
            S_WB: begin
                retire = 1'b1;
            end
            S_PAUSE: begin
                if (step_go || !step_mode) state_d = S_FETCH;
            end
            S_HALT: begin
                if (start) begin
                    state_d   = S_FETCH;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (retire) begin
            count_d = count_q + CW'(1);
            state_d = step_mode ? S_PAUSE : S_FETCH;
        end
    end

    // Outputs decode the registered state so reset clears them without a clock
    always_comb begin
        mem_rd      = (state_q == S_FETCH);
        ir_load     = (state_q == S_FETCH) && mem_ready;
        pc_inc      = (state_q == S_FETCH) && mem_ready;
        alu_en      = (state_q == S_EXEC);
        reg_we      = (state_q == S_WB);
        busy        = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC) ||
                      (state_q == S_WB) || (state_q == S_PAUSE);
        halted      = (state_q == S_HALT);
        timeout     = timeout_q;
        instr_count = count_q;
        case (state_q)
            S_DECODE: phase = 2'b01;
            S_EXEC:   phase = 2'b10;
            S_WB:     phase = 2'b11;
            default:  phase = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_cycle_controller.sv
// Self-checking bench for cycle_controller: per-instruction cycle plans built from the
// instruction timing rules, with random waits, opcodes and ignored-input noise.
module tb_cycle_controller;

    logic       clk;
    logic       clear_n;
    logic       start;
    logic       step_mode;
    logic       step_go;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       mem_rd;
    logic       ir_load;
    logic       pc_inc;
    logic       alu_en;
    logic       reg_we;
    logic [1:0] phase;
    logic       busy;
    logic       halted;
    logic       timeout;
    logic [7:0] instr_count;

    int total = 0;
    int bad   = 0;

    cycle_controller dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .start       (start),
        .step_mode   (step_mode),
        .step_go     (step_go),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .ir_load     (ir_load),
        .pc_inc      (pc_inc),
        .alu_en      (alu_en),
        .reg_we      (reg_we),
        .phase       (phase),
        .busy        (busy),
        .halted      (halted),
        .timeout     (timeout),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector: {mem_rd, ir_load, pc_inc, alu_en, reg_we, phase[1:0], busy, halted, timeout}
    localparam logic [9:0] V_IDLE  = 10'b0_0_0_0_0_00_0_0_0;
    localparam logic [9:0] V_FWAIT = 10'b1_0_0_0_0_00_1_0_0;
    localparam logic [9:0] V_FOK   = 10'b1_1_1_0_0_00_1_0_0;
    localparam logic [9:0] V_DEC   = 10'b0_0_0_0_0_01_1_0_0;
    localparam logic [9:0] V_EXE   = 10'b0_0_0_1_0_10_1_0_0;
    localparam logic [9:0] V_WB    = 10'b0_0_0_0_1_11_1_0_0;
    localparam logic [9:0] V_PAUSE = 10'b0_0_0_0_0_00_1_0_0;
    localparam logic [9:0] V_HALT  = 10'b0_0_0_0_0_00_0_1_0;
    localparam logic [9:0] V_HALTO = 10'b0_0_0_0_0_00_0_1_1;

    typedef struct {
        logic       mr;
        logic [3:0] op;
        logic       sg;
        logic       st;
        logic       sm;
        logic [9:0] ev;
        logic [7:0] ec;
    } cyc_t;

    cyc_t plan[$];
    int   model_count = 0;
    bit   noise = 0;
    logic cur_sm = 1'b0;

    function automatic logic [9:0] obs();
        return {mem_rd, ir_load, pc_inc, alu_en, reg_we, phase, busy, halted, timeout};
    endfunction

    function automatic logic rb();
        return noise ? logic'($urandom_range(0, 1)) : 1'b0;
    endfunction

    function automatic void push(logic mr, logic [3:0] op, logic sg, logic st, logic [9:0] ev);
        cyc_t c;
        c.mr = mr;
        c.op = op;
        c.sg = sg;
        c.st = st;
        c.sm = cur_sm;
        c.ev = ev;
        c.ec = 8'(model_count);
        plan.push_back(c);
    endfunction

    // One instruction: w wait cycles, fetch, decode, exec, optional writeback, then retire
    function automatic void add_instr(int w, logic [3:0] op, logic last_sg);
        for (int i = 0; i < w; i++) push(1'b0, 4'($urandom), rb(), rb(), V_FWAIT);
        push(1'b1, 4'($urandom), rb(), rb(), V_FOK);
        push(rb(), op, rb(), rb(), V_DEC);
        if (op == 4'hF) return;
        if (op == 4'h0) begin
            push(rb(), 4'($urandom), last_sg | rb(), rb(), V_EXE);
        end else begin
            push(rb(), 4'($urandom), rb(), rb(), V_EXE);
            push(rb(), 4'($urandom), last_sg | rb(), rb(), V_WB);
        end
        model_count = (model_count + 1) % 256;
    endfunction

    task automatic test_reset();
        clear_n = 1'b0; start = 1'b0; step_mode = 1'b0; step_go = 1'b0;
        opcode = 4'h0; mem_ready = 1'b0;
        #3;
        total++;
        if (obs() !== V_IDLE) begin
            bad++; $display("FAIL reset_outputs: got %b want %b", obs(), V_IDLE);
        end
        total++;
        if (instr_count !== 8'd0) begin
            bad++; $display("FAIL reset_count: got %0d want 0", instr_count);
        end
        repeat (2) @(posedge clk);
        #1 clear_n = 1'b1;
        @(negedge clk);
        total++;
        if (obs() !== V_IDLE) begin
            bad++; $display("FAIL idle_hold: got %b want %b", obs(), V_IDLE);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        cyc_t c;
        int   n = 0;
        noise = 0; cur_sm = 1'b0;
        push(1'b0, 4'h0, 1'b0, 1'b1, V_IDLE);
        add_instr(0, 4'h1, 1'b0);
        add_instr(0, 4'h2, 1'b0);
        add_instr(0, 4'h3, 1'b0);
        while (plan.size() != 0) begin
            c = plan.pop_front();
            mem_ready = c.mr; opcode = c.op; step_go = c.sg; start = c.st; step_mode = c.sm;
            @(negedge clk);
            total++;
            if ({obs(), instr_count} !== {c.ev, c.ec}) begin
                bad++;
                $display("FAIL basic cyc %0d: got %b cnt %0d want %b cnt %0d", n, obs(), instr_count, c.ev, c.ec);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_nop_sequence();
        cyc_t c;
        int   n = 0;
        noise = 0;
        add_instr(0, 4'h0, 1'b0);
        add_instr(0, 4'h0, 1'b0);
        add_instr(0, 4'h5, 1'b0);
        while (plan.size() != 0) begin
            c = plan.pop_front();
            mem_ready = c.mr; opcode = c.op; step_go = c.sg; start = c.st; step_mode = c.sm;
            @(negedge clk);
            total++;
            if ({obs(), instr_count} !== {c.ev, c.ec}) begin
                bad++;
                $display("FAIL nop cyc %0d: got %b cnt %0d want %b cnt %0d", n, obs(), instr_count, c.ev, c.ec);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random_stream();
        cyc_t c;
        int   n = 0;
        noise = 1;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) add_instr($urandom_range(0, 4), 4'h0, 1'b0);
            else add_instr($urandom_range(0, 4), 4'($urandom_range(1, 14)), 1'b0);
        end
        while (plan.size() != 0) begin
            c = plan.pop_front();
            mem_ready = c.mr; opcode = c.op; step_go = c.sg; start = c.st; step_mode = c.sm;
            @(negedge clk);
            total++;
            if ({obs(), instr_count} !== {c.ev, c.ec}) begin
                bad++;
                $display("FAIL random cyc %0d: got %b cnt %0d want %b cnt %0d", n, obs(), instr_count, c.ev, c.ec);
            end
            n++;
            @(posedge clk); #1;
        end
        noise = 0;
    endtask

    task automatic test_halt_op();
        cyc_t c;
        int   n = 0;
        add_instr(0, 4'h7, 1'b0);
        add_instr(0, 4'h8, 1'b0);
        add_instr(0, 4'hF, 1'b0);
        push(1'b1, 4'h3, 1'b1, 1'b0, V_HALT);
        push(1'b0, 4'h0, 1'b0, 1'b0, V_HALT);
        while (plan.size() != 0) begin
            c = plan.pop_front();
            mem_ready = c.mr; opcode = c.op; step_go = c.sg; start = c.st; step_mode = c.sm;
            @(negedge clk);
            total++;
            if ({obs(), instr_count} !== {c.ev, c.ec}) begin
                bad++;
                $display("FAIL halt_op cyc %0d: got %b cnt %0d want %b cnt %0d", n, obs(), instr_count, c.ev, c.ec);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        cyc_t c;
        int   n = 0;
        push(1'b0, 4'h0, 1'b0, 1'b1, V_HALT);
        add_instr(3, 4'h0, 1'b0);
        add_instr(14, 4'h5, 1'b0);
        for (int i = 0; i < 15; i++) push(1'b0, 4'h0, 1'b0, 1'b0, V_FWAIT);
        push(1'b1, 4'h0, 1'b0, 1'b0, V_HALTO);
        push(1'b0, 4'h0, 1'b0, 1'b1, V_HALTO);
        add_instr(0, 4'h1, 1'b0);
        while (plan.size() != 0) begin
            c = plan.pop_front();
            mem_ready = c.mr; opcode = c.op; step_go = c.sg; start = c.st; step_mode = c.sm;
            @(negedge clk);
            total++;
            if ({obs(), instr_count} !== {c.ev, c.ec}) begin
                bad++;
                $display("FAIL timeout cyc %0d: got %b cnt %0d want %b cnt %0d", n, obs(), instr_count, c.ev, c.ec);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_step_mode();
        cyc_t c;
        int   n = 0;
        noise = 1; cur_sm = 1'b1;
        add_instr(0, 4'h5, 1'b1);
        push(1'b1, 4'h0, 1'b0, 1'b1, V_PAUSE);
        push(1'b1, 4'h0, 1'b0, 1'b0, V_PAUSE);
        push(1'b0, 4'h0, 1'b1, 1'b0, V_PAUSE);
        add_instr(1, 4'h0, 1'b1);
        push(1'b0, 4'h0, 1'b0, 1'b0, V_PAUSE);
        cur_sm = 1'b0;
        push(1'b0, 4'h0, 1'b0, 1'b0, V_PAUSE);
        add_instr(0, 4'h6, 1'b0);
        while (plan.size() != 0) begin
            c = plan.pop_front();
            mem_ready = c.mr; opcode = c.op; step_go = c.sg; start = c.st; step_mode = c.sm;
            @(negedge clk);
            total++;
            if ({obs(), instr_count} !== {c.ev, c.ec}) begin
                bad++;
                $display("FAIL step cyc %0d: got %b cnt %0d want %b cnt %0d", n, obs(), instr_count, c.ev, c.ec);
            end
            n++;
            @(posedge clk); #1;
        end
        noise = 0;
    endtask

    task automatic test_async_reset();
        start = 1'b0; step_go = 1'b0; step_mode = 1'b0;
        mem_ready = 1'b1; opcode = 4'h0;
        @(negedge clk);
        @(posedge clk); #1;
        opcode = 4'h3;
        @(negedge clk);
        @(posedge clk); #1;
        opcode = 4'($urandom);
        @(negedge clk);
        total++;
        if (alu_en !== 1'b1) begin
            bad++; $display("FAIL areset_pre_alu: got %b want 1", alu_en);
        end
        #2 clear_n = 1'b0;
        #1;
        total++;
        if ({alu_en, busy} !== 2'b00) begin
            bad++; $display("FAIL areset_drop: got alu_en/busy %b want 00", {alu_en, busy});
        end
        total++;
        if (instr_count !== 8'd0) begin
            bad++; $display("FAIL areset_count: got %0d want 0", instr_count);
        end
        model_count = 0;
        @(posedge clk); #1;
        clear_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (obs() !== V_IDLE) begin
                bad++; $display("FAIL areset_idle %0d: got %b want %b", i, obs(), V_IDLE);
            end
            @(posedge clk); #1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (obs() !== V_FWAIT) begin
            bad++; $display("FAIL areset_restart: got %b want %b", obs(), V_FWAIT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        cyc_t c;
        int   n = 0;
        clear_n = 1'b0; start = 1'b0;
        #2 clear_n = 1'b1;
        model_count = 0;
        @(posedge clk); #1;
        noise = 1; cur_sm = 1'b0;
        push(1'b0, 4'h0, 1'b0, 1'b1, V_IDLE);
        for (int i = 0; i < 256; i++) add_instr(0, 4'h0, 1'b0);
        add_instr(1, 4'h9, 1'b0);
        while (plan.size() != 0) begin
            c = plan.pop_front();
            mem_ready = c.mr; opcode = c.op; step_go = c.sg; start = c.st; step_mode = c.sm;
            @(negedge clk);
            total++;
            if ({obs(), instr_count} !== {c.ev, c.ec}) begin
                bad++;
                $display("FAIL wrap cyc %0d: got %b cnt %0d want %b cnt %0d", n, obs(), instr_count, c.ev, c.ec);
            end
            n++;
            @(posedge clk); #1;
        end
        noise = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nop_sequence();
        test_random_stream();
        test_halt_op();
        test_timeout();
        test_step_mode();
        test_async_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cycle_controller.md
Name: cycle_controller

Overview:
Instruction-cycle sequencer for the basic CPU. It steps the datapath through FETCH, DECODE, EXECUTE and WRITEBACK phases and issues one-cycle control strobes (IR load, PC increment, ALU enable, register write). It supports free-run and single-step modes, a memory-ready handshake with a timeout, HALT detection, and a retired-instruction counter.

Parameters:
OPW, 4, opcode width in bits
CW, 8, instr_count width in bits
HALT_OP, 4'hF, opcode that halts the sequencer
NOP_OP, 4'h0, opcode that skips WRITEBACK
MAXWAIT, 15, FETCH cycles without mem_ready before timeout (1..255)

Ports:
clk  in  1  system clock, rising edge
clear_n  in  1  asynchronous active-low reset
start  in  1  begin/resume execution; honoured only in IDLE or HALT
step_mode  in  1  1 = pause after each retired instruction
step_go  in  1  advance one instruction while paused
opcode  in  OPW  current IR opcode; valid from the cycle after ir_load
mem_ready  in  1  memory has instruction word available
mem_rd  out  1  instruction read request (FETCH only)
ir_load  out  1  one-cycle strobe: load IR
pc_inc  out  1  one-cycle strobe: increment PC
alu_en  out  1  one-cycle strobe: ALU operate
reg_we  out  1  one-cycle strobe: register file write
phase  out  2  00 FETCH, 01 DECODE, 10 EXEC, 11 WB; 00 in IDLE/PAUSE/HALT
busy  out  1  1 in FETCH/DECODE/EXEC/WB/PAUSE
halted  out  1  1 in HALT
timeout  out  1  sticky memory-timeout flag
instr_count  out  CW  retired instructions, wraps modulo 2^CW

Behaviour:
- Reset (clear_n=0, async): state IDLE. Every output is 0, instr_count is 0, the wait counter and the latched opcode are 0. The block leaves reset on the first clk edge after clear_n rises.
- States: IDLE, FETCH, DECODE, EXEC, WB, PAUSE, HALT. All outputs are registered Moore outputs, except ir_load and pc_inc, which are combinational from FETCH & mem_ready.
- IDLE: if start=1, go to FETCH; otherwise stay.
- FETCH:
  - mem_rd=1 every cycle.
  - If mem_ready=1: ir_load=1 and pc_inc=1 in that same cycle, then go to DECODE.
  - If mem_ready=0: the wait counter increments. When MAXWAIT consecutive cycles pass with mem_ready=0, set timeout=1 and go to HALT.
  - The wait counter clears on every entry to FETCH.
- DECODE (1 cycle): latch opcode into op_q. If opcode==HALT_OP, go to HALT (not counted as retired). Otherwise go to EXEC.
- EXEC (1 cycle): alu_en=1. If op_q==NOP_OP, retire and skip WB. Otherwise go to WB.
- WB (1 cycle): reg_we=1, then retire.
- Retire: instr_count+1, wrapping from 2^CW-1 to 0. Then go to PAUSE if step_mode=1, else FETCH.
- PAUSE: strobes are 0 and busy=1. step_go=1 goes to FETCH. step_mode dropping to 0 also goes to FETCH. A step_go asserted in the retire cycle is ignored; it must be sampled while in PAUSE.
- HALT: halted=1 and busy=0. start=1 clears halted and timeout and goes to FETCH; instr_count is kept.
- Timing with no memory wait: a normal instruction takes 4 cycles (FETCH to WB) and a NOP takes 3. Each extra FETCH wait cycle adds 1.
- start in any state other than IDLE/HALT is ignored. step_go outside PAUSE is ignored.
- Simultaneous events:
  - mem_ready=1 on the MAXWAIT-th cycle means the fetch succeeds and there is no timeout.
  - In DECODE, the HALT_OP check takes priority over step_mode.
- Reset mid-operation aborts immediately: any active strobe drops within the reset assertion, with no clock needed.

Test Plan:
- Reset then start=1, mem_ready tied 1, opcodes 1,2,3 → phase sequence 00,01,10,11 repeating; ir_load/pc_inc/alu_en/reg_we each pulse once per 4 cycles; instr_count 0→1→2→3.
- Opcode sequence 0 (NOP), 0, 5 → no reg_we for the NOPs, 3-cycle NOP instructions; instr_count reaches 3 after 10 cycles.
- mem_ready held 0 for 3 cycles then 1 → mem_rd high for 4 cycles, ir_load only in the 4th. mem_ready held 0 for 15 cycles → timeout=1, halted=1, busy=0; then start → timeout=0, FETCH resumes.
- Opcode 4'hF after 2 instructions → halted=1 after DECODE, instr_count=2, no alu_en for HALT. Preload instr_count to 255 via 255 NOPs, then 1 more → instr_count=0.
- step_mode=1 → PAUSE after each retire (busy=1, phase=00). step_go pulsed in the retire cycle is ignored; step_go in PAUSE runs exactly one more instruction.
- clear_n pulsed low in the middle of EXEC with alu_en=1 → alu_en and busy go to 0 asynchronously and instr_count=0; after release, the block stays IDLE until start.
